yarp_decode_pipe: RTL and testbench
===================================

YARP_DECODE_PIPE -- requirements
Module: yarp_decode_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate and PC width; legal values are 32 or 64.
REQ-002 Parameter DEPTH, default 2, output queue entries; it SHALL be a power of 2 and at least 2.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  instruction offered.
REQ-006 in_ready  out  1  block can accept an instruction.
REQ-007 instr_i  in  32  raw RV32I instruction word.
REQ-008 pc_i  in  XLEN  PC of instr_i, passed through unchanged.
REQ-009 flush_i  in  1  discard all queued and incoming instructions.
REQ-010 out_valid  out  1  decoded bundle at queue head.
REQ-011 out_ready  in  1  consumer takes head bundle.
REQ-012 rs1_o/rs2_o/rd_o  out  5 each  register fields [19:15]/[24:20]/[11:7].
REQ-013 op_o  out  7, funct3_o  out  3, funct7_o  out  7  fields [6:0], [14:12], [31:25].
REQ-014 type_o  out  6  one-hot {j,u,b,s,i,r}; all zero when illegal.
REQ-015 illegal_o  out  1  opcode is not a supported RV32I base opcode.
REQ-016 imm_o  out  XLEN  sign-extended immediate.
REQ-017 pc_o  out  XLEN  PC of head bundle.

Function
REQ-018 The block SHALL push on in_valid&in_ready and pop on out_valid&out_ready, both at the same clock edge.
REQ-019 in_ready SHALL be (count<DEPTH) & ~flush_i; no push SHALL occur into a full queue, even when a pop occurs in the same cycle.
REQ-020 Latency SHALL be 1 cycle: an instruction pushed into an empty queue at edge N SHALL be presented with out_valid=1 after edge N.
REQ-021 Decode SHALL be combinational on instr_i before the push; the queue SHALL store the full decoded bundle.
REQ-022 Opcode map: 0110011 sets r; 0000011, 0010011, 1100111 set i; 0100011 sets s; 1100011 sets b; 0110111, 0010111 set u; 1101111 sets j; any other opcode sets illegal_o=1.
REQ-023 Immediates, each sign-extended from instr[31] to XLEN:
- i: instr[31:20].
- s: {instr[31:25], instr[11:7]}.
- b: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- u: {instr[31:12], 12'b0}.
- j: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- r and illegal: 0.
REQ-024 Register and funct fields SHALL be passed through for every opcode, including illegal ones.
REQ-025 Queue order SHALL be FIFO; read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-026 A simultaneous push and pop on a non-full, non-empty queue SHALL leave count unchanged.
REQ-027 flush_i=1 SHALL clear count and both pointers at that edge; any input offered in that cycle SHALL be dropped; out_valid SHALL be 0 in the next cycle.
REQ-028 flush_i SHALL take priority over push and pop in the same cycle.
REQ-029 Output fields SHALL be held stable while out_valid=1 and out_ready=0.

Reset
REQ-030 While reset=1: count=0, pointers=0, out_valid=0, in_ready=0.
REQ-031 While reset=1, all bundle outputs (fields, type_o, illegal_o, imm_o, pc_o) SHALL read 0.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries at the next edge.
REQ-033 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-034 XLEN=32: push 0xFFF10093 (addi x1,x2,-1), out_ready=1 -> next cycle out_valid=1, type_o=000010, rd=1, rs1=2, imm_o=0xFFFFFFFF.
REQ-035 XLEN=32: push 0xFFDFF06F (jal x0,-4) -> type_o=100000, imm_o=0xFFFFFFFC. XLEN=64: push 0x800002B7 (lui x5,0x80000) -> imm_o=0xFFFFFFFF80000000.
REQ-036 DEPTH=2, out_ready=0: offer A, B, C back-to-back -> A and B accepted, in_ready=0 while C is held. Then raise out_ready -> outputs A, B, C in order, with C accepted the cycle after the first pop.
REQ-037 Queue full and flush_i=1 with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the offered instruction never appears at the output.
REQ-038 Push 0x00000000 -> illegal_o=1, type_o=0, imm_o=0.
REQ-039 Queue holding 1 entry, reset pulsed for one cycle -> out_valid=0 afterwards, in_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/yarp_decode_pipe.sv
// RV32I decode stage with a small FIFO of decoded bundles.
// Decode is combinational ahead of the queue; head outputs read 0 in reset.
module yarp_decode_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [6:0]      op_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [5:0]      type_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] pc_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [5:0]      typ;
    logic            illegal;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } bundle_t;

  bundle_t         dec;
  bundle_t         head;
  bundle_t         mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  logic [6:0] op;
  logic is_r, is_i, is_s, is_b, is_u, is_j;

  logic signed [11:0] i_imm;
  logic signed [11:0] s_imm;
  logic signed [12:0] b_imm;
  logic signed [31:0] u_imm;
  logic signed [20:0] j_imm;

  assign op   = instr_i[6:0];
  assign is_r = (op == 7'b0110011);
  assign is_i = (op == 7'b0000011) | (op == 7'b0010011)
              | (op == 7'b1100111);
  assign is_s = (op == 7'b0100011);
  assign is_b = (op == 7'b1100011);
  assign is_u = (op == 7'b0110111) | (op == 7'b0010111);
  assign is_j = (op == 7'b1101111);

  assign i_imm = instr_i[31:20];
  assign s_imm = {instr_i[31:25], instr_i[11:7]};
  assign b_imm = {instr_i[31], instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign u_imm = {instr_i[31:12], 12'b0};
  assign j_imm = {instr_i[31], instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  always_comb begin
    dec        = '0;
    dec.rs1    = instr_i[19:15];
    dec.rs2    = instr_i[24:20];
    dec.rd     = instr_i[11:7];
    dec.op     = op;
    dec.funct3 = instr_i[14:12];
    dec.funct7 = instr_i[31:25];
    dec.pc     = pc_i;
    unique case (1'b1)
      is_r: dec.typ = 6'b000001;
      is_i: begin
        dec.typ = 6'b000010;
        dec.imm = XLEN'(i_imm);
      end
      is_s: begin
        dec.typ = 6'b000100;
        dec.imm = XLEN'(s_imm);
      end
      is_b: begin
        dec.typ = 6'b001000;
        dec.imm = XLEN'(b_imm);
      end
      is_u: begin
        dec.typ = 6'b010000;
        dec.imm = XLEN'(u_imm);
      end
      is_j: begin
        dec.typ = 6'b100000;
        dec.imm = XLEN'(j_imm);
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // A full queue never accepts, even if the head pops this cycle.
  assign in_ready  = (count < FULL) & ~flush_i & ~reset;
  assign out_valid = (count != '0) & ~reset;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset | flush_i) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= dec;
  end

  assign head = reset ? '0 : mem[rptr];

  assign rs1_o     = head.rs1;
  assign rs2_o     = head.rs2;
  assign rd_o      = head.rd;
  assign op_o      = head.op;
  assign funct3_o  = head.funct3;
  assign funct7_o  = head.funct7;
  assign type_o    = head.typ;
  assign illegal_o = head.illegal;
  assign imm_o     = head.imm;
  assign pc_o      = head.pc;

endmodule

// File: tb/tb_yarp_decode_pipe.sv
// Bench for yarp_decode_pipe: directed cases plus random traffic
// against a queue-based reference model.
module tb_yarp_decode_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, pc;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [5:0]  typ;
  logic        ill;
  logic [31:0] imm, pc_out;

  logic        v64_in, r64_in, v64_out;
  logic [31:0] instr64;
  logic [63:0] pc64, imm64, pc64_out;
  logic [4:0]  rs1_64, rs2_64, rd_64;
  logic [6:0]  op64, f7_64;
  logic [2:0]  f3_64;
  logic [5:0]  typ64;
  logic        ill64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  yarp_decode_pipe #(.XLEN(32), .DEPTH(2)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr_i(instr), .pc_i(pc), .flush_i(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
    .op_o(op), .funct3_o(f3), .funct7_o(f7),
    .type_o(typ), .illegal_o(ill),
    .imm_o(imm), .pc_o(pc_out)
  );

  yarp_decode_pipe #(.XLEN(64), .DEPTH(4)) u_dut64 (
    .clk(clk), .reset(reset),
    .in_valid(v64_in), .in_ready(r64_in),
    .instr_i(instr64), .pc_i(pc64), .flush_i(1'b0),
    .out_valid(v64_out), .out_ready(1'b1),
    .rs1_o(rs1_64), .rs2_o(rs2_64), .rd_o(rd_64),
    .op_o(op64), .funct3_o(f3_64), .funct7_o(f7_64),
    .type_o(typ64), .illegal_o(ill64),
    .imm_o(imm64), .pc_o(pc64_out)
  );

  typedef struct packed {
    logic [5:0]  typ;
    logic        ill;
    logic [63:0] imm;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Immediates built arithmetically from a sign-extended word.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic signed [63:0] s;
    s = {{32{w[31]}}, w};
    e = '0;
    case (w[6:0])
      7'h33: e.typ = 6'b000001;
      7'h03, 7'h13, 7'h67: begin
        e.typ = 6'b000010;
        e.imm = s >>> 20;
      end
      7'h23: begin
        e.typ = 6'b000100;
        e.imm = ((s >>> 25) << 5) | 64'(w[11:7]);
      end
      7'h63: begin
        e.typ = 6'b001000;
        e.imm = ((s >>> 31) << 12) | (64'(w[7]) << 11)
              | (64'(w[30:25]) << 5) | (64'(w[11:8]) << 1);
      end
      7'h37, 7'h17: begin
        e.typ = 6'b010000;
        e.imm = (s >>> 12) << 12;
      end
      7'h6f: begin
        e.typ = 6'b100000;
        e.imm = ((s >>> 31) << 20) | (64'(w[19:12]) << 12)
              | (64'(w[20]) << 11) | (64'(w[30:21]) << 1);
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check_head(input string tag, input ent_t x);
    exp_t e;
    e = model(x.instr);
    check({tag, "_fields"},
          {rs1, rs2, rd, op, f3, f7, typ, ill},
          {x.instr[19:15], x.instr[24:20], x.instr[11:7],
           x.instr[6:0], x.instr[14:12], x.instr[31:25],
           e.typ, e.ill});
    check({tag, "_imm_pc"}, {imm, pc_out}, {e.imm[31:0], x.pc});
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [31:0] w;
    ops = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23,
            7'h63, 7'h37, 7'h17, 7'h6f, 7'h00};
    w = $urandom;
    if ($urandom_range(0, 9) != 0)
      w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  initial begin
    ent_t x;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    out_ready = 1'b0; instr = '0; pc = '0;
    v64_in = 1'b0; instr64 = '0; pc64 = '0;

    cyc(); cyc();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_fields", {rs1, rs2, rd, op, f3, f7, typ, ill}, 0);
    check("rst_imm_pc", {imm, pc_out}, 0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1);

    // addi x1,x2,-1
    in_valid = 1'b1; instr = 32'hFFF10093; pc = 32'h100;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    #1;
    check("addi_valid", out_valid, 1);
    check("addi_type", typ, 6'b000010);
    check("addi_rd", rd, 1);
    check("addi_rs1", rs1, 2);
    check("addi_imm", imm, 32'hFFFFFFFF);
    check("addi_pc", pc_out, 32'h100);
    cyc();

    // jal x0,-4
    in_valid = 1'b1; instr = 32'hFFDFF06F; pc = 32'h200;
    cyc();
    in_valid = 1'b0;
    #1;
    check("jal_type", typ, 6'b100000);
    check("jal_imm", imm, 32'hFFFFFFFC);
    cyc();

    in_valid = 1'b1; instr = 32'h0;
    cyc();
    in_valid = 1'b0;
    #1;
    check("zero_illegal", ill, 1);
    check("zero_type", typ, 0);
    check("zero_imm", imm, 0);
    cyc();

    // Back-pressure: A, B fill the queue, C waits.
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h00100093;
    cyc();
    instr = 32'h00200113;
    cyc();
    instr = 32'h00300193;
    #1;
    check("full_ready0", in_ready, 0);
    cyc();
    check("held_ready0", in_ready, 0);
    check("held_rd_a", rd, 1);
    out_ready = 1'b1;
    #1;
    check("pop_full_ready0", in_ready, 0);
    cyc();
    check("order_b", rd, 2);
    check("c_ready", in_ready, 1);
    cyc();
    check("order_c", rd, 3);
    in_valid = 1'b0;
    cyc();
    check("drained", out_valid, 0);

    // Flush a full queue while offering D.
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h00100093;
    cyc();
    instr = 32'h00200113;
    cyc();
    flush = 1'b1; instr = 32'h00400213;
    #1;
    check("flush_ready0", in_ready, 0);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_valid0", out_valid, 0);
    check("flush_ready1", in_ready, 1);
    out_ready = 1'b1;
    cyc();
    check("flush_no_d", out_valid, 0);

    // Reset with one entry queued.
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h00500293;
    cyc();
    in_valid = 1'b0;
    #1;
    check("one_entry", out_valid, 1);
    reset = 1'b1;
    #1;
    check("midrst_valid0", out_valid, 0);
    check("midrst_ready0", in_ready, 0);
    check("midrst_rd0", rd, 0);
    cyc();
    reset = 1'b0;
    #1;
    check("after_rst_valid0", out_valid, 0);
    check("after_rst_ready1", in_ready, 1);

    // XLEN=64: lui x5,0x80000
    v64_in = 1'b1; instr64 = 32'h800002B7; pc64 = 64'h1_0000_0040;
    cyc();
    v64_in = 1'b0;
    #1;
    check("lui64_valid", v64_out, 1);
    check("lui64_type", typ64, 6'b010000);
    check("lui64_imm", imm64, 64'hFFFFFFFF80000000);
    check("lui64_pc", pc64_out, 64'h1_0000_0040);
    cyc();

    q.delete();
    for (int i = 0; i < 3000; i++) begin
      logic exp_rdy;
      logic do_pop;
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      instr     = rand_instr();
      pc        = $urandom;
      #1;
      exp_rdy = (q.size() < 2) && !flush;
      check("rnd_in_ready", in_ready, exp_rdy);
      check("rnd_out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) check_head("rnd", q[0]);
      do_pop = (q.size() > 0) && out_ready;
      if (flush) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (in_valid && exp_rdy) begin
          x.instr = instr;
          x.pc    = pc;
          q.push_back(x);
        end
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
